// File: rtl/sort_pipe_ctrl.sv
// sort_pipe_ctrl: flow control around a free-running sorting network.
// Tracks in-flight vectors, buffers results in order, applies credit backpressure.
module sort_pipe_ctrl #(
  parameter int width = 8,
  parameter int LAT   = 5,
  parameter int DEPTH = 8,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data [0:31],
  output logic [width-1:0] net_in [0:31],
  input  logic [width-1:0] net_out [0:31],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data [0:31],
  output logic [TAGW-1:0]  out_tag,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  logic             accept;
  logic             pop;
  logic             wr;
  logic [LAT-1:0]   pv;
  logic [TAGW-1:0]  ptag [LAT];
  logic [TAGW-1:0]  tag;
  logic [AW:0]      occ;
  logic [AW:0]      cnt;
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [width-1:0] mem [DEPTH][32];
  logic [TAGW-1:0]  tmem [DEPTH];

  assign net_in    = in_data;
  assign accept    = in_valid && in_ready;
  assign out_valid = (cnt != '0);
  assign pop       = out_valid && out_ready;
  assign wr        = pv[LAT-1];
  // occ counts credits, so the FIFO always has room for every arrival
  assign in_ready  = (occ < (AW+1)'(DEPTH));
  assign busy      = (occ != '0);
  assign out_data  = mem[rp];
  assign out_tag   = tmem[rp];

  always_ff @(posedge clk) begin
    if (!rst) begin
      pv <= '0;
    end else begin
      pv[0] <= accept;
      for (int i = 1; i < LAT; i++) pv[i] <= pv[i-1];
    end
  end

  always_ff @(posedge clk) begin
    ptag[0] <= tag;
    for (int i = 1; i < LAT; i++) ptag[i] <= ptag[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tag <= '0;
    end else if (accept) begin
      tag <= tag + TAGW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      occ <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      unique case ({wr, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wp]  <= net_out;
      tmem[wp] <= ptag[LAT-1];
    end
  end

endmodule
